writeback_controller: RTL

WRITEBACK_CONTROLLER -- requirements
Module: writeback_controller

---
 rtl/writeback_controller.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/writeback_controller.sv
// Writeback arbiter for the scalar and vector pipes.
// One single-entry buffer per register-file write port.
module wb_port #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cap_en,
  input  logic         v_en,
  input  logic         wb_sel,
  input  logic         drain_en,
  input  logic         s_en,
  input  logic [4:0]   s_reg,
  input  logic [W-1:0] s_data,
  input  logic [4:0]   v_reg,
  input  logic [W-1:0] v_data,
  output logic         wr_en,
  output logic [4:0]   wr_reg,
  output logic [W-1:0] wr_data,
  output logic         buf_valid,
  output logic         err
);

  typedef enum logic {EMPTY, HELD} state_t;

  state_t       state_q, state_d;
  logic [4:0]   breg_q;
  logic [W-1:0] bdata_q;
  logic         cap, load;
  logic         sel_buf, sel_vec, sel_scl;
  logic [4:0]   nxt_reg;
  logic [W-1:0] nxt_data;

  assign cap       = cap_en && v_en;
  assign buf_valid = (state_q == HELD);

  // Source priority: buffer > vector pipe > scalar pipe
  always_comb begin
    sel_buf  = drain_en && (state_q == HELD);
    sel_vec  = !sel_buf && wb_sel && v_en && !cap;
    sel_scl  = !sel_buf && !sel_vec && s_en;
    nxt_reg  = s_reg;
    nxt_data = s_data;
    unique case (1'b1)
      sel_buf: begin
        nxt_reg  = breg_q;
        nxt_data = bdata_q;
      end
      sel_vec: begin
        nxt_reg  = v_reg;
        nxt_data = v_data;
      end
      default: ;
    endcase
  end

  // Buffer FSM next state and protocol errors
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    err     = s_en && !sel_scl;
    unique case (state_q)
      EMPTY: begin
        if (drain_en) err = 1'b1;
        if (cap) begin
          load    = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        if (drain_en) begin
          if (cap) load = 1'b1;
          else state_d = EMPTY;
        end else if (cap) begin
          err = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Buffer contents and registered write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      breg_q  <= '0;
      bdata_q <= '0;
      wr_en   <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        breg_q  <= v_reg;
        bdata_q <= v_data;
      end
      wr_en <= sel_buf || sel_vec || sel_scl;
      if (sel_buf || sel_vec || sel_scl) begin
        wr_reg  <= nxt_reg;
        wr_data <= nxt_data;
      end
    end
  end

endmodule

module writeback_controller #(
  parameter int XLEN = 32,
  parameter int VLEN = 128
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_reg_wr_en,
  input  logic            s_vec_wr_en,
  input  logic [4:0]      s_wr_reg,
  input  logic [XLEN-1:0] s_reg_data,
  input  logic [VLEN-1:0] s_vec_data,
  input  logic            v_reg_wr_en,
  input  logic            v_vec_wr_en,
  input  logic [4:0]      v_wr_reg,
  input  logic [XLEN-1:0] v_reg_data,
  input  logic [VLEN-1:0] v_vec_data,
  input  logic            register_wb_sel,
  input  logic            vector_wb_sel,
  input  logic            buffer_register,
  input  logic            buffer_vector,
  input  logic            buffer_register_sel,
  input  logic            buffer_vector_sel,
  output logic            rf_wr_en,
  output logic [4:0]      rf_wr_reg,
  output logic [XLEN-1:0] rf_wr_data,
  output logic            vrf_wr_en,
  output logic [4:0]      vrf_wr_reg,
  output logic [VLEN-1:0] vrf_wr_data,
  output logic            reg_buf_valid,
  output logic            vec_buf_valid,
  output logic            wb_error
);

  logic err_r, err_v;

  wb_port #(.W(XLEN)) u_reg (
    .clk       (clk),
    .rst       (rst),
    .cap_en    (buffer_register),
    .v_en      (v_reg_wr_en),
    .wb_sel    (register_wb_sel),
    .drain_en  (buffer_register_sel),
    .s_en      (s_reg_wr_en),
    .s_reg     (s_wr_reg),
    .s_data    (s_reg_data),
    .v_reg     (v_wr_reg),
    .v_data    (v_reg_data),
    .wr_en     (rf_wr_en),
    .wr_reg    (rf_wr_reg),
    .wr_data   (rf_wr_data),
    .buf_valid (reg_buf_valid),
    .err       (err_r)
  );

  wb_port #(.W(VLEN)) u_vec (
    .clk       (clk),
    .rst       (rst),
    .cap_en    (buffer_vector),
    .v_en      (v_vec_wr_en),
    .wb_sel    (vector_wb_sel),
    .drain_en  (buffer_vector_sel),
    .s_en      (s_vec_wr_en),
    .s_reg     (s_wr_reg),
    .s_data    (s_vec_data),
    .v_reg     (v_wr_reg),
    .v_data    (v_vec_data),
    .wr_en     (vrf_wr_en),
    .wr_reg    (vrf_wr_reg),
    .wr_data   (vrf_wr_data),
    .buf_valid (vec_buf_valid),
    .err       (err_v)
  );

  // Sticky protocol-violation flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wb_error <= 1'b0;
    else if (err_r || err_v) wb_error <= 1'b1;
  end

endmodule
